// File: rtl/soc_system_st_timing_adapter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_st_timing_adapter_fifo
// Brief    : Avalon-ST timing adapter. Upstream ready latency IN_RL (0..3) to
//            downstream ready latency 0, with a DEPTH-entry buffer.
//            Optional SOC_ST_TIMING_ADT_OVF_COUNT_EN builds a dropped-beat counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module soc_system_st_timing_adapter_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int IN_RL  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow,
    output logic [15:0]       ovf_count
);
    localparam int                c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_CNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_PTR = c_ADDR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_in_ready;
    logic                r_overflow;

    logic                w_wr_req;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [c_CNT_W-1:0]  w_count_nxt;

    // With a non-zero ready latency the beat was already committed upstream,
    // so it is taken whether or not in_ready is high right now.
    assign w_wr_req = (IN_RL == 0) ? (in_valid && r_in_ready) : in_valid;
    assign w_pop    = (r_count != '0) && out_ready;
    assign w_full   = (r_count == c_FULL);
    assign w_push   = w_wr_req && (!w_full || w_pop);
    assign w_drop   = w_wr_req && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_ADDR_W'(1);
            end
            r_count    <= w_count_nxt;
            // Registered decode of the next occupancy keeps out_ready/in_valid
            // off the in_ready timing path.
            r_in_ready <= ((int'(w_count_nxt) + IN_RL) < DEPTH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

`ifdef SOC_ST_TIMING_ADT_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = 16'h0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && w_drop) begin
            $warning("soc_system_st_timing_adapter_fifo: beat dropped, buffer full");
        end
    end
`endif

endmodule
`default_nettype wire
